sm83_irq_dispatch: RTL
======================

Name: sm83_irq_dispatch

Overview:
- Parametrised interrupt dispatch unit for the sm83 core. It generalises the fixed 8-line irq/iack path to NUM_IRQS lines with a configurable vector map.
- Owns the IME flag with its EI delay, HALT/wake handling and the 5-M-cycle dispatch sequence.
- Performs late priority resolution and drives a one-hot iack pulse.
- Sits between the IF&IE-masked request lines and sm83_control; control consumes dispatch_req and the vector.

Parameters:
NUM_IRQS, 8, number of interrupt lines; bit 0 is the highest priority.
VEC_BASE, 16'h0040, vector of line 0.
VEC_STRIDE, 8, byte distance between consecutive vectors (power of two).
EI_DELAY, 1, number of instruction boundaries between EI and IME=1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ncyc  in  1  M-cycle advance strobe; all state below changes only when ncyc=1, except reset
irq  in  NUM_IRQS  level requests, already masked with IE
instr_end  in  1  current instruction completes this M-cycle
op_ei  in  1  EI executed (qualified with instr_end)
op_di  in  1  DI executed
op_reti  in  1  RETI executed
op_halt  in  1  HALT executed
dispatch_req  out  1  control starts the interrupt sequence at the next M1 instead of fetching
disp_m  out  3  dispatch M-cycle index 0..4; 7 when idle
vector  out  16  ISR address, valid from M-cycle 4 of the dispatch
iack  out  NUM_IRQS  one-hot for one M-cycle; clears the IF bit
ime  out  1  interrupt master enable
halted  out  1  core halted; clock-gate hint
halt_bug  out  1  one-shot: next opcode fetch must not increment PC

Behaviour:
- Reset values: ime=0, halted=0, halt_bug=0, dispatch_req=0, disp_m=7, vector=0, iack=0, EI counter=0.
- Reset mid-dispatch aborts the sequence; no iack is issued.
- IME state machine: DIS -> EI_WAIT on op_ei&instr_end.
  - EI_WAIT counts EI_DELAY instr_end events, then -> EN.
  - op_di in any state -> DIS, and cancels EI_WAIT.
  - op_reti -> EN immediately, with no delay.
  - Dispatch entry -> DIS.
  - op_ei while EN stays EN.
- pending = |irq.
- Dispatch trigger: at instr_end with ime=1 and pending, assert dispatch_req for that ncyc. State -> DISP, disp_m=0.
- DISP sequencing: disp_m increments on each ncyc through 0,1,2,3,4, then returns to 7 (idle).
  - M0–M1: idle cycles; control decrements SP.
  - M2: control pushes PC high byte.
  - M3: control pushes PC low byte. At the end of M3, priority is resolved from the current irq: lowest set index k. This is the late-latch point.
  - M4: vector=VEC_BASE+k*VEC_STRIDE, and iack[k]=1 for this M-cycle only.
  - If irq==0 at the M3 resolve point (request withdrawn, e.g. IF cleared by the push), then vector=16'h0000 and iack=0.
  - vector holds its value until the next dispatch.
- HALT handling:
  - op_halt&instr_end with no pending -> halted=1.
  - While halted: pending wakes the core on the next ncyc (halted=0). If ime=1, the dispatch sequence starts; otherwise execution resumes without dispatch.
  - op_halt&instr_end with ime=0 and pending: halted stays 0 and halt_bug=1 for exactly one ncyc.
  - With ime=1 and pending at HALT: no halt; dispatch proceeds.
- Simultaneous events: op_ei and op_di in the same cycle -> DI wins.
- op_ei during DISP is ignored (no instructions execute during DISP).
- Arithmetic: k*VEC_STRIDE is computed in 16 bits and wraps modulo 2^16.

Decomposition:
- Package sm83_irq_pkg holds:
  - the ime_state_t enum (DIS, EI_WAIT, EN);
  - the disp_state_t enum (RUN, HALT, DISP);
  - the DISP_IDLE=3'd7 constant.
- Sub-module sm83_irq_prio: combinational, parametrised NUM_IRQS. Outputs the one-hot lowest set bit, its index, and a valid flag. Instantiated once, at the M3 resolve point.

Test Plan:
- EI then NOP with irq=8'h04: IME=1 after the NOP; dispatch at the next instr_end; vector=0x0050; iack=8'h04 at disp_m=4; ime=0.
- irq=8'h14 during dispatch with ime=1: vector=0x0050, iack=8'h04. Clear irq bit 2 before the M3 end with irq=8'h10 remaining: vector=0x0060, iack=8'h10.
- Request withdrawn before the M3 end (irq=0): vector=0x0000, iack=0, ime=0.
- HALT with ime=0, irq=0 -> halted=1. Raise irq=8'h01: halted=0 after one ncyc; no dispatch_req.
- HALT with ime=0, irq=8'h02 -> halted stays 0 and halt_bug is high for one ncyc.
- NUM_IRQS=16, VEC_STRIDE=16, irq=16'h8000: vector=0x0130. EI then DI in the same instruction window: IME stays 0 and no dispatch occurs. Reset at disp_m=2: all outputs return to their reset values and iack is never asserted.

Source files
------------

// File: rtl/sm83_irq_pkg.sv
// Shared types and helpers for the sm83 interrupt dispatch unit.
package sm83_irq_pkg;

    // Interrupt master enable: disabled, waiting out the EI delay, enabled.
    typedef enum logic [1:0] {
        DIS     = 2'd0,
        EI_WAIT = 2'd1,
        EN      = 2'd2
    } ime_state_t;

    // Core activity as seen by the dispatcher.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DISP = 2'd2
    } disp_state_t;

    // disp_m value reported while no dispatch sequence is running.
    localparam logic [2:0] DISP_IDLE = 3'd7;

    // ISR address for line idx; the sum and product wrap modulo 2^16.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input logic [15:0] idx,
                                             input logic [15:0] stride);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/sm83_irq_dispatch_if.sv
// Request/acknowledge bundle between sm83_control and the interrupt dispatcher.
interface sm83_irq_dispatch_if #(
    parameter int NUM_IRQS = 8
);
    logic                ncyc;
    logic [NUM_IRQS-1:0] irq;
    logic                instr_end;
    logic                op_ei;
    logic                op_di;
    logic                op_reti;
    logic                op_halt;
    logic                dispatch_req;
    logic [2:0]          disp_m;
    logic [15:0]         vector;
    logic [NUM_IRQS-1:0] iack;
    logic                ime;
    logic                halted;
    logic                halt_bug;

    // Control side: drives the timing strobes and decoded opcodes.
    modport master (
        output ncyc, irq, instr_end, op_ei, op_di, op_reti, op_halt,
        input  dispatch_req, disp_m, vector, iack, ime, halted, halt_bug
    );

    // Dispatcher side.
    modport slave (
        input  ncyc, irq, instr_end, op_ei, op_di, op_reti, op_halt,
        output dispatch_req, disp_m, vector, iack, ime, halted, halt_bug
    );
endinterface

// File: rtl/sm83_irq_prio.sv
// Fixed-priority resolver: bit 0 wins. Pure combinational.
module sm83_irq_prio #(
    parameter int NUM_IRQS = 8,
    parameter int IDX_W    = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1
) (
    input  logic [NUM_IRQS-1:0] req,
    output logic [NUM_IRQS-1:0] onehot,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = |req;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sm83_irq_dispatch.sv
// Interrupt dispatch unit: IME with EI delay, HALT/wake, 5-M-cycle dispatch
// with late priority resolution at the end of M3.
module sm83_irq_dispatch
    import sm83_irq_pkg::*;
#(
    parameter int          NUM_IRQS   = 8,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8,
    parameter int          EI_DELAY   = 1
) (
    input logic                clk,
    input logic                reset,
    sm83_irq_dispatch_if.slave bus
);

    localparam int               IDX_W    = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;
    localparam int               CNT_W    = (EI_DELAY > 0) ? $clog2(EI_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] EI_LAST  = CNT_W'((EI_DELAY > 0) ? EI_DELAY - 1 : 0);
    localparam logic [15:0]      STRIDE16 = 16'(VEC_STRIDE);

    ime_state_t          ime_q, ime_d;
    disp_state_t         disp_q, disp_d;
    logic [2:0]          disp_m_q, disp_m_d;
    logic [CNT_W-1:0]    ei_cnt_q, ei_cnt_d;
    logic [15:0]         vector_q, vector_d;
    logic [NUM_IRQS-1:0] iack_q, iack_d;
    logic                halt_bug_q, halt_bug_d;

    logic                pending;
    logic                ime_on;
    logic                run_end;
    logic                wake;
    logic                trigger;

    logic [NUM_IRQS-1:0] prio_onehot;
    logic [IDX_W-1:0]    prio_idx;
    logic                prio_valid;

    // Resolves the live request lines; only sampled at the end of M3.
    sm83_irq_prio #(
        .NUM_IRQS (NUM_IRQS),
        .IDX_W    (IDX_W)
    ) u_prio (
        .req    (bus.irq),
        .onehot (prio_onehot),
        .idx    (prio_idx),
        .valid  (prio_valid)
    );

    // Event qualifiers: an instruction boundary, a halt wake-up, and the dispatch trigger.
    always_comb begin
        pending = |bus.irq;
        ime_on  = (ime_q == EN);
        run_end = bus.ncyc && (disp_q == RUN) && bus.instr_end;
        wake    = bus.ncyc && (disp_q == HALT) && pending;
        trigger = (run_end || wake) && ime_on && pending;
    end

    // Next-state logic for the core-activity FSM, the dispatch sequence and IME.
    always_comb begin
        disp_d     = disp_q;
        disp_m_d   = disp_m_q;
        vector_d   = vector_q;
        iack_d     = iack_q;
        halt_bug_d = halt_bug_q;
        ime_d      = ime_q;
        ei_cnt_d   = ei_cnt_q;

        if (bus.ncyc) begin
            // halt_bug only ever lives for the single M-cycle after HALT.
            halt_bug_d = 1'b0;

            case (disp_q)
                RUN: begin
                    if (bus.instr_end) begin
                        if (trigger) begin
                            disp_d   = DISP;
                            disp_m_d = 3'd0;
                        end else if (bus.op_halt) begin
                            // With a pending request and IME off the core does
                            // not halt, but the next fetch repeats the byte.
                            if (!pending) begin
                                disp_d = HALT;
                            end else begin
                                halt_bug_d = 1'b1;
                            end
                        end
                    end
                end
                HALT: begin
                    if (pending) begin
                        if (ime_on) begin
                            disp_d   = DISP;
                            disp_m_d = 3'd0;
                        end else begin
                            disp_d = RUN;
                        end
                    end
                end
                DISP: begin
                    if (disp_m_q == 3'd3) begin
                        // Late latch: whichever line is still asserted now wins.
                        vector_d = prio_valid ? vec_addr(VEC_BASE, 16'(prio_idx), STRIDE16)
                                              : 16'h0000;
                        iack_d   = prio_onehot;
                        disp_m_d = 3'd4;
                    end else if (disp_m_q == 3'd4) begin
                        iack_d   = '0;
                        disp_d   = RUN;
                        disp_m_d = DISP_IDLE;
                    end else begin
                        disp_m_d = 3'(disp_m_q + 3'd1);
                    end
                end
                default: begin
                    disp_d   = RUN;
                    disp_m_d = DISP_IDLE;
                end
            endcase

            // IME only reacts to completed instructions; dispatch entry overrides all.
            if (trigger) begin
                ime_d    = DIS;
                ei_cnt_d = '0;
            end else if (run_end) begin
                if (bus.op_di) begin
                    ime_d    = DIS;
                    ei_cnt_d = '0;
                end else if (bus.op_reti) begin
                    ime_d    = EN;
                    ei_cnt_d = '0;
                end else begin
                    case (ime_q)
                        DIS: begin
                            if (bus.op_ei) begin
                                ime_d    = (EI_DELAY == 0) ? EN : EI_WAIT;
                                ei_cnt_d = '0;
                            end
                        end
                        EI_WAIT: begin
                            if (ei_cnt_q == EI_LAST) begin
                                ime_d    = EN;
                                ei_cnt_d = '0;
                            end else begin
                                ei_cnt_d = CNT_W'(ei_cnt_q + 1'b1);
                            end
                        end
                        EN:      ime_d = EN;
                        default: ime_d = DIS;
                    endcase
                end
            end
        end
    end

    // State register; reset aborts any dispatch in flight before iack can fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q     <= RUN;
            disp_m_q   <= DISP_IDLE;
            vector_q   <= 16'h0000;
            iack_q     <= '0;
            halt_bug_q <= 1'b0;
            ime_q      <= DIS;
            ei_cnt_q   <= '0;
        end else begin
            disp_q     <= disp_d;
            disp_m_q   <= disp_m_d;
            vector_q   <= vector_d;
            iack_q     <= iack_d;
            halt_bug_q <= halt_bug_d;
            ime_q      <= ime_d;
            ei_cnt_q   <= ei_cnt_d;
        end
    end

    assign bus.dispatch_req = trigger;
    assign bus.disp_m       = disp_m_q;
    assign bus.vector       = vector_q;
    assign bus.iack         = iack_q;
    assign bus.ime          = ime_on;
    assign bus.halted       = (disp_q == HALT);
    assign bus.halt_bug     = halt_bug_q;

endmodule
